// File: rtl/fp_int_pkg.sv
// Shared definitions for the FP-INT MAC datapath: FP16 field widths, the
// multiplier FSM encoding and the product-width rule used by the accumulator.
package fp_int_pkg;

  localparam int FP16_EXP_WIDTH = 5;
  localparam int FP16_MAN_WIDTH = 10;
  localparam logic [FP16_EXP_WIDTH-1:0] FP16_EXP_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Significand (MAN+1 bits) times |weight| (up to 2^(W-1)) fits in MAN+W bits.
  function automatic int prod_width(input int man_width, input int w_width);
    return man_width + w_width;
  endfunction

endpackage

// File: rtl/serial_shift_add.sv
// Horner shift-add register: each enabled cycle doubles the accumulator and
// adds the significand when the current weight bit (MSB first) is set.
module serial_shift_add
  import fp_int_pkg::*;
#(
  parameter int PROD_WIDTH = 14,
  parameter int SIG_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  bit_in,
  input  logic [SIG_WIDTH-1:0]  sig,
  output logic [PROD_WIDTH-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= {acc[PROD_WIDTH-2:0], 1'b0} + (bit_in ? PROD_WIDTH'(sig) : '0);
    end
  end

endmodule

// File: rtl/fp_int_mul_serial.sv
// Bit-serial FP16 x signed-INTn multiplier: captures operands, runs W_WIDTH
// Horner steps and presents sign, effective exponent and unnormalised magnitude.
module fp_int_mul_serial
  import fp_int_pkg::*;
#(
  parameter int  W_WIDTH    = 4,
  parameter int  EXP_WIDTH  = FP16_EXP_WIDTH,
  parameter int  MAN_WIDTH  = FP16_MAN_WIDTH,
  localparam int PROD_WIDTH = prod_width(MAN_WIDTH, W_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1+EXP_WIDTH+MAN_WIDTH-1:0] activation,
  input  logic [W_WIDTH-1:0]             weight,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sign_out,
  output logic [EXP_WIDTH-1:0]           exp_out,
  output logic [PROD_WIDTH-1:0]          mag_out,
  output logic                           zero_out,
  output logic                           special_out
);

  localparam int ACT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int CNT_WIDTH = $clog2(W_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W_WIDTH - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  state_t                 state_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [MAN_WIDTH:0]     sig_reg;
  logic [W_WIDTH-1:0]     wmag_reg;
  logic                   s_reg;
  logic [EXP_WIDTH-1:0]   e_reg;
  logic                   z_reg;
  logic                   sp_reg;
  logic [PROD_WIDTH-1:0]  acc;

  logic                   act_sign;
  logic [EXP_WIDTH-1:0]   act_exp;
  logic [MAN_WIDTH-1:0]   act_man;
  logic                   exp_zero;
  logic [W_WIDTH-1:0]     wmag_next;
  logic                   accept;

  assign act_sign = activation[ACT_WIDTH-1];
  assign act_exp  = activation[MAN_WIDTH +: EXP_WIDTH];
  assign act_man  = activation[MAN_WIDTH-1:0];
  assign exp_zero = (act_exp == '0);
  // Two's-complement negate; the most negative weight maps to 2^(W-1) unsigned.
  assign wmag_next = weight[W_WIDTH-1] ? (~weight + W_WIDTH'(1)) : weight;
  assign accept    = in_valid && in_ready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      sig_reg       <= '0;
      wmag_reg      <= '0;
      s_reg         <= 1'b0;
      e_reg         <= '0;
      z_reg         <= 1'b0;
      sp_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sig_reg      <= {~exp_zero, act_man};
            wmag_reg     <= wmag_next;
            s_reg        <= act_sign ^ weight[W_WIDTH-1];
            e_reg        <= exp_zero ? EXP_WIDTH'(1) : act_exp;
            z_reg        <= (weight == '0) || (exp_zero && (act_man == '0));
            sp_reg       <= (act_exp == EXP_ONES);
            cnt_reg      <= CNT_LAST;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (cnt_reg == '0) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_WIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  serial_shift_add #(
    .PROD_WIDTH (PROD_WIDTH),
    .SIG_WIDTH  (MAN_WIDTH + 1)
  ) u_shift_add (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state_reg == RUN),
    .bit_in (wmag_reg[cnt_reg]),
    .sig    (sig_reg),
    .acc    (acc)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;

  // Inf/NaN wins over zero: the mantissa is passed through so the consumer can tell them apart.
  always_comb begin
    sign_out    = 1'b0;
    exp_out     = '0;
    mag_out     = '0;
    zero_out    = 1'b0;
    special_out = 1'b0;
    if (out_valid_reg) begin
      if (sp_reg) begin
        sign_out    = s_reg;
        exp_out     = EXP_ONES;
        mag_out     = PROD_WIDTH'(sig_reg[MAN_WIDTH-1:0]);
        special_out = 1'b1;
      end else if (z_reg) begin
        exp_out  = e_reg;
        zero_out = 1'b1;
      end else begin
        sign_out = s_reg;
        exp_out  = e_reg;
        mag_out  = acc;
      end
    end
  end

endmodule

// File: tb/tb_fp_int_mul_serial.sv
// Self-checking bench for fp_int_mul_serial at W_WIDTH = 4, 2 and 8, using a
// value-level reference model of the FP16 x INT product.
module tb_fp_int_mul_serial;
  import fp_int_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [17:0] mag;
    logic        zero;
    logic        special;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic        in_ready4, out_valid4, sign4, zero4, special4;
  logic [15:0] act4 = '0;
  logic [3:0]  w4 = '0;
  logic [4:0]  exp4;
  logic [13:0] mag4;

  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic        in_ready2, out_valid2, sign2, zero2, special2;
  logic [15:0] act2 = '0;
  logic [1:0]  w2 = '0;
  logic [4:0]  exp2;
  logic [11:0] mag2;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic        in_ready8, out_valid8, sign8, zero8, special8;
  logic [15:0] act8 = '0;
  logic [7:0]  w8 = '0;
  logic [4:0]  exp8;
  logic [17:0] mag8;

  always #5 clk = ~clk;

  fp_int_mul_serial dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .activation(act4), .weight(w4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sign_out(sign4), .exp_out(exp4), .mag_out(mag4), .zero_out(zero4), .special_out(special4)
  );

  fp_int_mul_serial #(.W_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .activation(act2), .weight(w2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sign_out(sign2), .exp_out(exp2), .mag_out(mag2), .zero_out(zero2), .special_out(special2)
  );

  fp_int_mul_serial #(.W_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .activation(act8), .weight(w8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sign_out(sign8), .exp_out(exp8), .mag_out(mag8), .zero_out(zero8), .special_out(special8)
  );

  // Reference: real-valued meaning of the operands, reduced to the output fields.
  function automatic res_t model(input logic [15:0] act, input int wbits, input int wdt);
    res_t r;
    int   e, m, wv, absw;
    e    = int'(act[14:10]);
    m    = int'(act[9:0]);
    wv   = (wbits >= (1 << (wdt - 1))) ? wbits - (1 << wdt) : wbits;
    absw = (wv < 0) ? -wv : wv;
    r.special = (e == 31);
    r.zero    = !r.special && ((wv == 0) || (e == 0 && m == 0));
    r.sign    = r.zero ? 1'b0 : (act[15] ^ (wv < 0));
    r.exp     = r.special ? FP16_EXP_ONES : ((e == 0) ? 5'd1 : 5'(e));
    r.mag     = r.special ? 18'(m) : (r.zero ? 18'd0 : 18'((((e != 0) ? 1024 : 0) + m) * absw));
    return r;
  endfunction

  function automatic res_t obs4();
    return {sign4, exp4, 4'b0, mag4, zero4, special4};
  endfunction
  function automatic res_t obs2();
    return {sign2, exp2, 6'b0, mag2, zero2, special2};
  endfunction
  function automatic res_t obs8();
    return {sign8, exp8, mag8, zero8, special8};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hands one operand pair to the W=4 instance and waits (bounded) for its result.
  task automatic send4(input logic [15:0] a, input logic [3:0] w, output int lat);
    int guard;
    guard = 0;
    while (!in_ready4 && guard < 50) begin
      tick();
      guard++;
    end
    act4 = a;
    w4 = w;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    act4 = 16'($urandom);
    w4 = 4'($urandom);
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs4: got in_ready=%b out_valid=%b want 1 0", in_ready4, out_valid4);
    end
    checks++;
    if (obs4() !== '0) begin
      errors++;
      $display("FAIL reset_out4: got %h want 0", obs4());
    end
    checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs2_8: got %b%b %b%b want 10 10", in_ready2, out_valid2, in_ready8, out_valid8);
    end
  endtask

  task automatic test_directed();
    logic [15:0] acts [6];
    logic [3:0]  ws [6];
    res_t exp_r, got;
    int lat;
    acts = '{16'h3C00, 16'h3C00, 16'hBE00, 16'h0001, 16'h4500, 16'h7C00};
    ws   = '{4'b0011, 4'b1000, 4'b1111, 4'b0111, 4'b0000, 4'b1110};
    for (int i = 0; i < 6; i++) begin
      send4(acts[i], ws[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat);
      end
      exp_r = model(acts[i], int'(ws[i]), 4);
      got = obs4();
      checks++;
      if (got !== exp_r) begin
        errors++;
        $display("FAIL dir_result[%0d]: got %h want %h", i, got, exp_r);
      end
      if (i == 0) begin
        checks++;
        if (mag4 !== 14'h0C00 || exp4 !== 5'd15 || sign4 !== 1'b0) begin
          errors++;
          $display("FAIL one_times_three: got s=%b e=%0d m=%h want 0 15 0c00", sign4, exp4, mag4);
        end
      end
      $display("txn W=4 act=%h w=%h sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
               acts[i], ws[i], sign4, exp4, mag4, zero4, special4);
      release4();
    end
  endtask

  task automatic test_backpressure();
    res_t exp_r;
    int lat;
    send4(16'h4A55, 4'b1011, lat);
    exp_r = model(16'h4A55, 11, 4);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid4 = ~in_valid4;
      act4 = 16'($urandom);
      w4 = 4'($urandom);
      tick();
      checks++;
      if (obs4() !== exp_r || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h rdy=%b vld=%b want %h 0 1", i, obs4(), in_ready4, out_valid4, exp_r);
      end
    end
    in_valid4 = 1'b0;
    $display("txn W=4 act=4a55 w=b sign=%0d exp=%0d mag=%h zero=%0d special=%0d (held)",
             sign4, exp4, mag4, zero4, special4);
    release4();
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t exp_r;
    logic accepting;
    int last_acc;
    last_acc = -1;
    out_ready4 = 1'b1;
    act4 = 16'($urandom);
    w4 = 4'($urandom);
    for (int cyc = 0; cyc < 70; cyc++) begin
      in_valid4 = (cyc < 60);
      accepting = in_ready4 && in_valid4;
      if (out_valid4) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: got result %h want none", obs4());
        end else begin
          exp_r = q.pop_front();
          if (obs4() !== exp_r) begin
            errors++;
            $display("FAIL b2b_result: got %h want %h", obs4(), exp_r);
          end
        end
        $display("txn W=4 b2b sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
                 sign4, exp4, mag4, zero4, special4);
      end
      if (accepting) q.push_back(model(act4, int'(w4), 4));
      tick();
      if (accepting) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            errors++;
            $display("FAIL b2b_period: got %0d want 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        act4 = 16'($urandom);
        w4 = 4'($urandom);
      end
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    checks++;
    if (q.size() != 0 || last_acc < 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending, last accept %0d want 0 pending", q.size(), last_acc);
    end
  endtask

  task automatic test_reset_mid_run();
    res_t exp_r;
    logic seen;
    int lat;
    act4 = 16'h3C00;
    w4 = 4'b0101;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || obs4() !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b out=%h want 1 0 0", in_ready4, out_valid4, obs4());
    end
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid4) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_result: got out_valid=1 want 0");
    end
    send4(16'hC100, 4'b0110, lat);
    exp_r = model(16'hC100, 6, 4);
    checks++;
    if (lat !== 4 || obs4() !== exp_r) begin
      errors++;
      $display("FAIL after_reset: got lat=%0d %h want 4 %h", lat, obs4(), exp_r);
    end
    $display("txn W=4 act=c100 w=6 sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
             sign4, exp4, mag4, zero4, special4);
    release4();
  endtask

  task automatic test_random_w4();
    logic [15:0] a;
    logic [3:0] w;
    res_t exp_r;
    int lat, r;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      r = int'($urandom_range(0, 7));
      if (r == 0) a[14:10] = 5'd0;
      if (r == 1) a[14:10] = 5'h1F;
      w = 4'($urandom);
      send4(a, w, lat);
      exp_r = model(a, int'(w), 4);
      checks++;
      if (lat !== 4 || obs4() !== exp_r) begin
        errors++;
        $display("FAIL rand_w4[%0d]: got lat=%0d %h want 4 %h", i, lat, obs4(), exp_r);
      end
      $display("txn W=4 act=%h w=%h sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
               a, w, sign4, exp4, mag4, zero4, special4);
      release4();
    end
  endtask

  task automatic test_random_w2();
    logic [15:0] a;
    logic [1:0] w;
    res_t exp_r;
    int lat, guard;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      if (i % 5 == 1) a[14:10] = 5'h1F;
      w = (i == 0) ? 2'b10 : 2'($urandom);
      guard = 0;
      while (!in_ready2 && guard < 50) begin
        tick();
        guard++;
      end
      act2 = a;
      w2 = w;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      act2 = 16'($urandom);
      lat = 0;
      while (!out_valid2 && lat < 50) begin
        tick();
        lat++;
      end
      exp_r = model(a, int'(w), 2);
      checks++;
      if (lat !== 2 || obs2() !== exp_r) begin
        errors++;
        $display("FAIL rand_w2[%0d]: got lat=%0d %h want 2 %h", i, lat, obs2(), exp_r);
      end
      $display("txn W=2 act=%h w=%h sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
               a, w, sign2, exp2, mag2, zero2, special2);
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
    end
  endtask

  task automatic test_random_w8();
    logic [15:0] a;
    logic [7:0] w;
    res_t exp_r;
    int lat, guard;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      if (i % 5 == 1) a[14:10] = 5'd0;
      w = (i == 0) ? 8'h80 : 8'($urandom);
      guard = 0;
      while (!in_ready8 && guard < 50) begin
        tick();
        guard++;
      end
      act8 = a;
      w8 = w;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      w8 = 8'($urandom);
      lat = 0;
      while (!out_valid8 && lat < 50) begin
        tick();
        lat++;
      end
      exp_r = model(a, int'(w), 8);
      checks++;
      if (lat !== 8 || obs8() !== exp_r) begin
        errors++;
        $display("FAIL rand_w8[%0d]: got lat=%0d %h want 8 %h", i, lat, obs8(), exp_r);
      end
      $display("txn W=8 act=%h w=%h sign=%0d exp=%0d mag=%h zero=%0d special=%0d",
               a, w, sign8, exp8, mag8, zero8, special8);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random_w4();
    test_random_w2();
    test_random_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
